// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage RV core.
// - Detects load-use hazards against a registered shadow of the instruction in EX.
// - Inserts a one-cycle bubble for a load-use hazard.
// - Flushes wrong-path work when a taken branch resolves in MEM.
// - Keeps saturating debug counters of stall cycles and flush events.
module hazard_control_unit #(
  parameter int CNT_W     = 16,
  parameter int FLUSH_CYC = 1   // 1..3 cycles of bubble/IF-ID flush after a taken branch
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             branch_taken,
  output logic             control_sel,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // RV32/64 base opcodes that matter for source-register usage
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Flush cycles remaining after the branch cycle itself
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t     state;
  logic       ex_memread;   // instruction now in EX is a load
  logic [4:0] ex_rd;        // destination of the instruction now in EX
  logic [1:0] flush_cnt;    // remaining FLUSH-state cycles

  logic uses_rs1;
  logic uses_rs2;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;

  // Decode which source registers the instruction in ID actually reads
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_REG, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD: begin
        uses_rs1 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // x0 is never a real dependency, so a load targeting x0 cannot cause a stall
  assign rs1_hit  = uses_rs1 && (ex_rd == id_rs1);
  assign rs2_hit  = uses_rs2 && (ex_rd == id_rs2);
  assign load_use = ex_memread && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  // Drive pipeline control; a taken branch beats everything since younger work is wrong-path
  always_comb begin
    control_sel  = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst) begin
      if (branch_taken) begin
        control_sel  = 1'b1;
        if_id_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (state == FLUSH) begin
        control_sel  = 1'b1;
        if_id_flush  = 1'b1;
      end else if ((state == RUN) && load_use) begin
        control_sel  = 1'b1;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
      end
    end
  end

  // State machine, EX shadow and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      ex_memread  <= 1'b0;
      ex_rd       <= 5'd0;
      flush_cnt   <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      // A bubble entering EX carries no load and no destination
      if (control_sel) begin
        ex_memread <= 1'b0;
        ex_rd      <= 5'd0;
      end else begin
        ex_memread <= (id_opcode == OP_LOAD);
        ex_rd      <= id_rd;
      end

      if (branch_taken) begin
        flush_cnt <= FLUSH_RELOAD;
        state     <= (FLUSH_CYC > 1) ? FLUSH : RUN;
        if (flush_count != {CNT_W{1'b1}}) begin
          flush_count <= flush_count + 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (load_use) begin
              state <= BUBBLE;
              if (stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + 1'b1;
              end
            end
          end
          BUBBLE: begin
            // The bubble now sits in EX, so the stalled pair cannot re-trigger
            state <= RUN;
          end
          FLUSH: begin
            flush_cnt <= flush_cnt - 2'd1;
            if (flush_cnt <= 2'd1) begin
              state <= RUN;
            end
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Two instances share the stimulus:
// index 0 runs with FLUSH_CYC=1, index 1 with FLUSH_CYC=3, both with 4-bit counters.
// A pipeline-level model predicts every output each cycle; literal checks pin key points.
module tb_hazard_control_unit;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] SD   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] id_opcode = ADDI;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       branch_taken = 1'b0;

  logic          cs_o  [2];
  logic          pcw_o [2];
  logic          ifw_o [2];
  logic          iff_o [2];
  logic          emf_o [2];
  logic [CW-1:0] sc_o  [2];
  logic [CW-1:0] fc_o  [2];

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;
  int cycle  = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(CW), .FLUSH_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .branch_taken(branch_taken), .control_sel(cs_o[0]), .pc_write(pcw_o[0]),
    .if_id_write(ifw_o[0]), .if_id_flush(iff_o[0]), .ex_mem_flush(emf_o[0]),
    .stall_count(sc_o[0]), .flush_count(fc_o[0])
  );

  hazard_control_unit #(.CNT_W(CW), .FLUSH_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .branch_taken(branch_taken), .control_sel(cs_o[1]), .pc_write(pcw_o[1]),
    .if_id_write(ifw_o[1]), .if_id_flush(iff_o[1]), .ex_mem_flush(emf_o[1]),
    .stall_count(sc_o[1]), .flush_count(fc_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cycle, act, exp);
    end
  endtask

  // Model of the pipeline as seen by the hazard logic: what sits in EX,
  // how many flush cycles remain, and the event tallies.
  bit m_ex_load [2];
  int m_ex_rd   [2];
  int m_left    [2];
  int m_stalls  [2];
  int m_flushes [2];

  function automatic bit reads_rs1(input logic [6:0] op);
    return (op == ADD) || (op == ADDI) || (op == LD) || (op == SD) || (op == BEQ);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == ADD) || (op == SD) || (op == BEQ);
  endfunction

  // Compare every instance against the model each cycle, then advance the model
  always @(negedge clk) begin
    if (run) begin
      for (int d = 0; d < 2; d++) begin
        int fc;
        bit dep, e_cs, e_pcw, e_ifw, e_iff, e_emf, stall;
        fc    = (d == 0) ? 1 : 3;
        dep   = m_ex_load[d] && (m_ex_rd[d] != 0) &&
                ((reads_rs1(id_opcode) && m_ex_rd[d] == int'(id_rs1)) ||
                 (reads_rs2(id_opcode) && m_ex_rd[d] == int'(id_rs2)));
        e_cs = 0; e_pcw = 1; e_ifw = 1; e_iff = 0; e_emf = 0; stall = 0;
        if (!rst) begin
          if (branch_taken) begin
            e_cs = 1; e_iff = 1; e_emf = 1;
          end else if (m_left[d] > 0) begin
            e_cs = 1; e_iff = 1;
          end else if (dep) begin
            e_cs = 1; e_pcw = 0; e_ifw = 0; stall = 1;
          end
        end
        chk($sformatf("d%0d control_sel", d),  int'(cs_o[d]),  int'(e_cs));
        chk($sformatf("d%0d pc_write", d),     int'(pcw_o[d]), int'(e_pcw));
        chk($sformatf("d%0d if_id_write", d),  int'(ifw_o[d]), int'(e_ifw));
        chk($sformatf("d%0d if_id_flush", d),  int'(iff_o[d]), int'(e_iff));
        chk($sformatf("d%0d ex_mem_flush", d), int'(emf_o[d]), int'(e_emf));
        chk($sformatf("d%0d stall_count", d),  int'(sc_o[d]),  m_stalls[d]);
        chk($sformatf("d%0d flush_count", d),  int'(fc_o[d]),  m_flushes[d]);
        if (rst) begin
          m_ex_load[d] = 0; m_ex_rd[d] = 0; m_left[d] = 0;
          m_stalls[d] = 0; m_flushes[d] = 0;
        end else begin
          if (branch_taken) begin
            m_left[d] = fc - 1;
            if (m_flushes[d] < CNT_MAX) m_flushes[d]++;
          end else if (m_left[d] > 0) begin
            m_left[d]--;
          end
          if (stall && m_stalls[d] < CNT_MAX) m_stalls[d]++;
          if (e_cs) begin
            m_ex_load[d] = 0; m_ex_rd[d] = 0;
          end else begin
            m_ex_load[d] = (id_opcode == LD); m_ex_rd[d] = int'(id_rd);
          end
        end
      end
    end
  end

  // One instruction slot: drive just after the edge, return at the sampling point
  task automatic apply(input logic r, input logic [6:0] op, input int rs1, input int rs2,
                       input int rd, input logic br);
    @(posedge clk);
    #1;
    run          = 1'b1;
    cycle++;
    rst          = r;
    id_opcode    = op;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rd        = 5'(rd);
    branch_taken = br;
    $display("cycle %0d: rst=%0b op=%b rs1=%0d rs2=%0d rd=%0d br=%0b", cycle, r, op, rs1, rs2, rd, br);
    @(negedge clk);
  endtask

  task automatic nop();
    apply(1'b0, ADDI, 0, 0, 0, 1'b0);
  endtask

  initial begin
    // Reset
    apply(1'b1, ADDI, 0, 0, 0, 1'b0);
    apply(1'b1, ADDI, 0, 0, 0, 1'b0);
    nop();
    chk("reset pc_write", int'(pcw_o[0]), 1);
    chk("reset stall_count", int'(sc_o[0]), 0);

    // ld x5 ; add x6,x5,x7 -> one stall cycle
    apply(1'b0, LD, 1, 0, 5, 1'b0);
    apply(1'b0, ADD, 5, 7, 6, 1'b0);
    chk("ld-add control_sel", int'(cs_o[0]), 1);
    chk("ld-add pc_write", int'(pcw_o[0]), 0);
    chk("ld-add if_id_write", int'(ifw_o[0]), 0);
    apply(1'b0, ADD, 5, 7, 6, 1'b0);
    chk("after stall control_sel", int'(cs_o[0]), 0);
    chk("after stall stall_count", int'(sc_o[0]), 1);
    nop();

    // ld x0 ; add x6,x0,x7 -> no stall
    apply(1'b0, LD, 1, 0, 0, 1'b0);
    apply(1'b0, ADD, 0, 7, 6, 1'b0);
    chk("ld x0 no stall", int'(cs_o[0]), 0);

    // ld x5 ; addi x6,x7,4 -> no stall
    apply(1'b0, LD, 1, 0, 5, 1'b0);
    apply(1'b0, ADDI, 7, 4, 6, 1'b0);
    chk("ld-addi no stall", int'(cs_o[0]), 0);

    // ld x5 ; sd x5,0(x8) -> stall through rs2
    apply(1'b0, LD, 1, 0, 5, 1'b0);
    apply(1'b0, SD, 8, 5, 0, 1'b0);
    chk("ld-sd control_sel", int'(cs_o[0]), 1);
    apply(1'b0, SD, 8, 5, 0, 1'b0);
    chk("ld-sd stall_count", int'(sc_o[0]), 2);
    nop();

    // Taken branch pulse
    apply(1'b0, ADDI, 0, 0, 0, 1'b1);
    chk("br d0 ex_mem_flush", int'(emf_o[0]), 1);
    chk("br d0 if_id_flush", int'(iff_o[0]), 1);
    chk("br d0 pc_write", int'(pcw_o[0]), 1);
    nop();
    chk("br+1 d0 control_sel", int'(cs_o[0]), 0);
    chk("br+1 d0 flush_count", int'(fc_o[0]), 1);
    chk("br+1 d1 control_sel", int'(cs_o[1]), 1);
    chk("br+1 d1 ex_mem_flush", int'(emf_o[1]), 0);
    nop();
    chk("br+2 d1 if_id_flush", int'(iff_o[1]), 1);
    nop();
    chk("br+3 d1 control_sel", int'(cs_o[1]), 0);

    // Branch and load-use together: flush wins, stall not counted
    apply(1'b0, LD, 1, 0, 5, 1'b0);
    apply(1'b0, ADD, 5, 7, 6, 1'b1);
    chk("br+lu pc_write", int'(pcw_o[0]), 1);
    chk("br+lu ex_mem_flush", int'(emf_o[0]), 1);
    nop();
    chk("br+lu stall_count", int'(sc_o[0]), 2);
    nop();
    nop();

    // Branch retaken while still flushing
    apply(1'b0, ADDI, 0, 0, 0, 1'b1);
    nop();
    apply(1'b0, ADDI, 0, 0, 0, 1'b1);
    nop();
    chk("retake d1 flush_count", int'(fc_o[1]), 4);
    nop();
    nop();
    nop();

    // Saturate the stall counter
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, LD, 1, 0, 5, 1'b0);
      apply(1'b0, ADD, 5, 7, 6, 1'b0);
      apply(1'b0, ADD, 5, 7, 6, 1'b0);
    end
    chk("saturated stall_count", int'(sc_o[0]), CNT_MAX);
    apply(1'b0, LD, 1, 0, 5, 1'b0);
    apply(1'b0, ADD, 5, 7, 6, 1'b0);
    apply(1'b0, ADD, 5, 7, 6, 1'b0);
    chk("held stall_count", int'(sc_o[0]), CNT_MAX);

    // Reset in the middle of a FLUSH_CYC=3 flush
    apply(1'b0, ADDI, 0, 0, 0, 1'b1);
    apply(1'b1, ADDI, 0, 0, 0, 1'b0);
    apply(1'b0, LD, 1, 0, 5, 1'b0);
    chk("post-rst d1 control_sel", int'(cs_o[1]), 0);
    chk("post-rst d1 stall_count", int'(sc_o[1]), 0);
    chk("post-rst d1 flush_count", int'(fc_o[1]), 0);
    apply(1'b0, ADD, 5, 7, 6, 1'b0);
    chk("post-rst d1 stall", int'(cs_o[1]), 1);
    apply(1'b0, ADD, 5, 7, 6, 1'b0);
    chk("post-rst d1 stall_count", int'(sc_o[1]), 1);
    nop();

    @(posedge clk);
    #1;
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
